uart_rx_frame_ctrl: RTL and testbench

Sequences the UART receiver's byte stream into checked packets and presents each good packet to downstream logic over a valid/ready stream.
- Frame format: SYNC_BYTE, LEN, LEN payload bytes, CHK, where CHK = XOR of LEN and all payload bytes.
- Payload is held in an internal buffer and released only after CHK matches; bad or stalled frames are discarded and flagged.
- Sits between uart_receiver (data/ready outputs) and the command/register logic.

---
 rtl/uart_rx_frame_ctrl.sv | 172 +++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// Frames the UART byte stream (SYNC, LEN, payload, CHK), verifies the XOR check and
// releases good payloads over a valid/ready stream; bad, oversized or stalled frames are flagged.
module uart_rx_frame_ctrl #(
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
    parameter int unsigned MAX_LEN       = 16,
    parameter int unsigned TIMEOUT_TICKS = 3000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_ready_i,
    output logic [7:0] out_data_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic       out_last_o,
    output logic       busy_o,
    output logic       pkt_ok_o,
    output logic       err_chk_o,
    output logic       err_len_o,
    output logic       err_timeout_o,
    output logic [7:0] drop_count_o
);
    localparam int unsigned PtrW  = $clog2(MAX_LEN + 1);
    localparam int unsigned IdxW  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned TickW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
    localparam logic [7:0]       MaxLen8  = 8'(MAX_LEN);
    localparam logic [TickW-1:0] TickLast = TickW'(TIMEOUT_TICKS - 1);
    localparam logic [PtrW-1:0]  PtrOne   = PtrW'(1);

    typedef enum logic [2:0] {StIdle, StLen, StPayload, StCheck, StDrain} state_e;

    state_e            state_q, state_d;
    logic              rx_ready_q;
    logic [PtrW-1:0]   len_q, len_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]        chk_q, chk_d;
    logic [TickW-1:0]  tick_q, tick_d;
    logic [7:0]        drop_q, drop_d;
    logic              pkt_ok_q, pkt_ok_d;
    logic              err_chk_q, err_chk_d;
    logic              err_len_q, err_len_d;
    logic              err_tmo_q, err_tmo_d;
    logic [7:0]        buf_q [MAX_LEN];
    logic              buf_we;
    logic              byte_stb;
    logic              tick_expired;

    assign byte_stb     = rx_ready_i & ~rx_ready_q;
    assign tick_expired = (tick_q == TickLast);

    assign out_valid_o   = (state_q == StDrain);
    assign out_data_o    = out_valid_o ? buf_q[rd_ptr_q[IdxW-1:0]] : 8'h00;
    assign out_last_o    = out_valid_o && (rd_ptr_q == len_q - PtrOne);
    assign busy_o        = (state_q != StIdle);
    assign pkt_ok_o      = pkt_ok_q;
    assign err_chk_o     = err_chk_q;
    assign err_len_o     = err_len_q;
    assign err_timeout_o = err_tmo_q;
    assign drop_count_o  = drop_q;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        chk_d     = chk_q;
        tick_d    = '0;
        drop_d    = drop_q;
        pkt_ok_d  = 1'b0;
        err_chk_d = 1'b0;
        err_len_d = 1'b0;
        err_tmo_d = 1'b0;
        buf_we    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (byte_stb && rx_data_i == SYNC_BYTE) state_d = StLen;
            end
            StLen: begin
                if (byte_stb) begin
                    if (rx_data_i == 8'h00 || rx_data_i > MaxLen8) begin
                        err_len_d = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        len_d    = rx_data_i[PtrW-1:0];
                        chk_d    = rx_data_i;
                        wr_ptr_d = '0;
                        state_d  = StPayload;
                    end
                end else if (tick_expired) begin
                    err_tmo_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            StPayload: begin
                if (byte_stb) begin
                    buf_we   = 1'b1;
                    chk_d    = chk_q ^ rx_data_i;
                    wr_ptr_d = wr_ptr_q + PtrOne;
                    if (wr_ptr_q == len_q - PtrOne) state_d = StCheck;
                end else if (tick_expired) begin
                    err_tmo_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            StCheck: begin
                if (byte_stb) begin
                    if (rx_data_i == chk_q) begin
                        pkt_ok_d = 1'b1;
                        rd_ptr_d = '0;
                        state_d  = StDrain;
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = StIdle;
                    end
                end else if (tick_expired) begin
                    err_tmo_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            StDrain: begin
                // Input is not back-pressured, so bytes arriving while draining are lost.
                if (byte_stb && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                if (out_ready_i) begin
                    rd_ptr_d = rd_ptr_q + PtrOne;
                    if (out_last_o) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            rx_ready_q <= 1'b1;
            len_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            chk_q      <= '0;
            tick_q     <= '0;
            drop_q     <= '0;
            pkt_ok_q   <= 1'b0;
            err_chk_q  <= 1'b0;
            err_len_q  <= 1'b0;
            err_tmo_q  <= 1'b0;
            for (int i = 0; i < int'(MAX_LEN); i++) buf_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            rx_ready_q <= rx_ready_i;
            len_q      <= len_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            chk_q      <= chk_d;
            tick_q     <= tick_d;
            drop_q     <= drop_d;
            pkt_ok_q   <= pkt_ok_d;
            err_chk_q  <= err_chk_d;
            err_len_q  <= err_len_d;
            err_tmo_q  <= err_tmo_d;
            if (buf_we) buf_q[wr_ptr_q[IdxW-1:0]] <= rx_data_i;
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: frame-level stimulus pushes expected pulses and payload bytes
// into queues; a negedge monitor pops and compares whenever the DUT presents them.
`timescale 1ns/1ps
module tb_uart_rx_frame_ctrl;
    localparam logic [7:0]  Sync   = 8'hA5;
    localparam int unsigned MaxLen = 16;
    localparam int unsigned Tmo    = 3000;
    localparam int EvOk = 0, EvChk = 1, EvLen = 2, EvTmo = 3;

    typedef struct {logic [7:0] data; logic last; int cyc;} out_t;
    typedef struct {int code; int cyc;} evt_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_valid, out_last, busy;
    logic       pkt_ok, err_chk, err_len, err_timeout;
    logic [7:0] drop_count;

    int         cyc = 0;
    int         last_stb = 0;
    int         checks = 0;
    int         failures = 0;
    int         exp_drop = 0;
    bit         rand_ready = 1'b0;
    out_t       exp_out[$];
    evt_t       exp_evt[$];
    logic [7:0] pay[$];
    string      pname[4] = '{"pkt_ok", "err_chk", "err_len", "err_timeout"};

    uart_rx_frame_ctrl #(
        .SYNC_BYTE    (Sync),
        .MAX_LEN      (MaxLen),
        .TIMEOUT_TICKS(Tmo)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .rx_data_i    (rx_data),
        .rx_ready_i   (rx_ready),
        .out_data_o   (out_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_last_o   (out_last),
        .busy_o       (busy),
        .pkt_ok_o     (pkt_ok),
        .err_chk_o    (err_chk),
        .err_len_o    (err_len),
        .err_timeout_o(err_timeout),
        .drop_count_o (drop_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: any pulse must match the head of the event queue, any valid byte the head of
    // the output queue (also while stalled, which pins data/last stable).
    always @(negedge clk) begin : monitor
        logic [3:0] p;
        evt_t       e;
        if (!reset) begin
            p = {err_timeout, err_len, err_chk, pkt_ok};
            for (int k = 0; k < 4; k++) begin
                if (p[k]) begin
                    if (exp_evt.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_%s: got 1 expected 0 (cycle %0d)", pname[k], cyc);
                    end else begin
                        e = exp_evt.pop_front();
                        check("pulse_kind", k, e.code);
                        check("pulse_cycle", cyc, e.cyc);
                    end
                end
            end
            if (out_valid) begin
                if (exp_out.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out_valid: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    check("out_data", out_data, exp_out[0].data);
                    check("out_last", out_last, exp_out[0].last);
                    if (out_ready) begin
                        if (exp_out[0].cyc >= 0) check("out_cycle", cyc, exp_out[0].cyc);
                        void'(exp_out.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait until d cycles after the previous strobe (two minimum, so rx_ready can fall).
    task automatic wait_slot(input int d);
        int dd;
        dd = (d < 2) ? 2 : d;
        while (cyc < last_stb + dd) tick(1);
    endtask

    // A rising rx_ready driven now is processed in cycle `cyc`.
    task automatic strobe(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        last_stb = cyc;
        tick(1);
        rx_ready = 1'b0;
    endtask

    task automatic push_evt(input int code, input int at);
        evt_t e;
        e.code = code;
        e.cyc  = at;
        exp_evt.push_back(e);
    endtask

    function automatic int rdly();
        return int'($urandom_range(2, 5));
    endfunction

    function automatic logic [7:0] frame_xor(input int len);
        logic [7:0] x;
        x = 8'(len);
        foreach (pay[i]) x ^= pay[i];
        return x;
    endfunction

    task automatic fill_pay(input int len);
        pay.delete();
        for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
    endtask

    // Sends SYNC, LEN, pay, chk_sent; the expected outcome follows from LEN legality and
    // the XOR rule. `timed` means out_ready stays high, so output cycles are exact.
    task automatic send_frame(input int len, input logic [7:0] chk_sent, input bit timed);
        out_t o;
        wait_slot(rdly());
        strobe(Sync);
        wait_slot(rdly());
        if (len == 0 || len > int'(MaxLen)) begin
            push_evt(EvLen, cyc + 1);
            strobe(8'(len));
            return;
        end
        strobe(8'(len));
        foreach (pay[i]) begin
            wait_slot(rdly());
            strobe(pay[i]);
        end
        wait_slot(rdly());
        if (chk_sent == frame_xor(len)) begin
            push_evt(EvOk, cyc + 1);
            foreach (pay[i]) begin
                o.data = pay[i];
                o.last = (i == len - 1);
                o.cyc  = timed ? cyc + 1 + i : -1;
                exp_out.push_back(o);
            end
        end else begin
            push_evt(EvChk, cyc + 1);
        end
        strobe(chk_sent);
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n;
        n = 0;
        while ((busy || exp_out.size() != 0) && n < bound) begin
            tick(1);
            n++;
        end
        checks++;
        if (n >= bound) begin
            failures++;
            $display("FAIL %s: still busy after %0d cycles, expected idle", name, bound);
        end
    endtask

    initial begin
        out_t o;
        int   s;
        int   len;
        logic [7:0] chk;

        // Reset with rx_ready already high: that level must not count as a byte.
        rx_ready = 1'b1;
        rx_data  = Sync;
        tick(3);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_pulses", {pkt_ok, err_chk, err_len, err_timeout}, 4'b0000);
        check("rst_drop_count", drop_count, 8'h00);
        reset = 1'b0;
        tick(4);
        check("ready_high_at_release", busy, 1'b0);
        rx_ready = 1'b0;
        tick(2);
        check("ready_high_after_drop", busy, 1'b0);
        last_stb = cyc;

        // Good 3-byte frame, then the same with a wrong CHK, then another good one.
        pay = '{8'h11, 8'h22, 8'h33};
        send_frame(3, 8'h03, 1'b1);
        wait_idle("good_frame_drain", 100);
        send_frame(3, 8'h04, 1'b1);
        tick(3);
        check("bad_chk_busy", busy, 1'b0);
        fill_pay(5);
        send_frame(5, frame_xor(5), 1'b1);
        wait_idle("after_bad_chk_drain", 100);

        // Illegal LEN values; the following 03 is plain noise in IDLE.
        send_frame(0, 8'h00, 1'b1);
        wait_slot(2);
        strobe(8'h03);
        tick(3);
        check("len0_busy", busy, 1'b0);
        send_frame(17, 8'h00, 1'b1);
        wait_slot(2);
        strobe(8'h03);
        tick(3);
        check("len17_busy", busy, 1'b0);
        check("noise_not_dropped", drop_count, 8'(exp_drop));

        // Inter-byte timeout inside PAYLOAD.
        wait_slot(2); strobe(Sync);
        wait_slot(2); strobe(8'h02);
        wait_slot(2); strobe(8'h44);
        s = last_stb;
        push_evt(EvTmo, s + int'(Tmo) + 1);
        while (cyc < s + int'(Tmo) + 5) tick(1);
        check("timeout_busy", busy, 1'b0);

        // A byte landing exactly on the expiry cycle is taken instead.
        wait_slot(2); strobe(Sync);
        wait_slot(2); strobe(8'h02);
        wait_slot(2); strobe(8'h44);
        wait_slot(int'(Tmo));
        strobe(8'h55);
        wait_slot(2);
        push_evt(EvOk, cyc + 1);
        o.data = 8'h44; o.last = 1'b0; o.cyc = cyc + 1; exp_out.push_back(o);
        o.data = 8'h55; o.last = 1'b1; o.cyc = cyc + 2; exp_out.push_back(o);
        strobe(8'h02 ^ 8'h44 ^ 8'h55);
        wait_idle("expiry_race_drain", 100);

        // Stalled drain with three bytes arriving meanwhile.
        out_ready = 1'b0;
        fill_pay(4);
        send_frame(4, frame_xor(4), 1'b0);
        fork
            begin
                repeat (3) begin
                    wait_slot(2);
                    strobe(8'($urandom));
                    exp_drop++;
                end
            end
            begin
                int g;
                g = 0;
                tick(10);
                while (exp_out.size() > 0 && g < 200) begin
                    out_ready = ~out_ready;
                    tick(1);
                    g++;
                end
                out_ready = 1'b1;
            end
        join
        wait_idle("stall_drain", 100);
        check("drop_count", drop_count, 8'(exp_drop));

        // Reset in the middle of the payload.
        wait_slot(2); strobe(Sync);
        wait_slot(2); strobe(8'h04);
        wait_slot(2); strobe(8'h11);
        wait_slot(2); strobe(8'h22);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        exp_drop = 0;
        check("reset_mid_payload_busy", busy, 1'b0);
        check("reset_clears_drops", drop_count, 8'(exp_drop));
        tick(5);
        last_stb = cyc;
        fill_pay(2);
        send_frame(2, frame_xor(2), 1'b1);
        wait_idle("after_reset_drain", 100);

        // Randomised frames with random back-pressure.
        rand_ready = 1'b1;
        for (int f = 0; f < 30; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                chk = 8'($urandom);
                if (chk == Sync) chk = 8'h5A;
                wait_slot(rdly());
                strobe(chk);
            end
            len = int'($urandom_range(0, 18));
            fill_pay((len >= 1 && len <= int'(MaxLen)) ? len : 0);
            chk = frame_xor(len);
            if ($urandom_range(0, 3) == 0) chk ^= 8'(1 << $urandom_range(0, 7));
            send_frame(len, chk, 1'b0);
            wait_idle("random_drain", 400);
        end
        rand_ready = 1'b0;
        tick(2);
        out_ready = 1'b1;
        wait_idle("final_drain", 100);
        tick(3);
        check("pending_outputs", exp_out.size(), 0);
        check("pending_events", exp_evt.size(), 0);
        check("final_drop_count", drop_count, 8'(exp_drop));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation still running at cycle %0d, expected finish", cyc);
        $fatal(1, "global timeout");
    end

endmodule
